// File: rtl/fetch_pkg.sv
// fetch_pkg: shared opcode constants, queue entry type and immediate decoders
// for the instruction-fetch front end.
package fetch_pkg;

  // Width of the pc field carried in each queue entry; fetch_unit's XLEN must match it.
  localparam int PKG_XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic                pred_taken;
  } fetch_entry_t;

  // Sign-extended B-type immediate (conditional branches).
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  // Sign-extended J-type immediate (JAL).
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous queue of fetch entries. The head is read
// straight out of register storage, so it holds still while nothing is popped.
// flush empties the queue in one edge; reset also clears the storage so the
// head reads as zero out of reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_pop;

  assign full   = (count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rptr];

  // Pointer, occupancy and storage update; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_entry;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one request per cycle to a 1-cycle-latency
// instruction memory and queues {pc, instr} for decode behind a valid/ready
// handshake. Execute redirects with redirect_valid, which flushes everything.
// Optional feature macro: FETCH_STATIC_PREDICT_EN (JAL and backward branches
// predicted taken at queue-push time, costing one bubble).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = PKG_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_pred_taken
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            drop;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            issue;
  logic            push;
  logic            pop;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] redirect_target;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Only issue when the queue is guaranteed room for the response, counting
  // the one already in flight; a redirect cycle never issues.
  assign issue    = !reset && !redirect_valid && ((int'(count) + int'(inflight)) < DEPTH);
  assign imem_req  = issue;
  assign imem_addr = pc;

  // The issue rule already keeps the queue from overflowing; !full is a hard backstop.
  assign push = inflight && !drop && !redirect_valid && !full;
  assign pop  = out_valid && out_ready;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign push_entry      = '{pc: inflight_pc, instr: imem_rdata, pred_taken: pred_taken};

  assign out_valid      = !empty;
  assign out_pc         = head.pc;
  assign out_instr      = head.instr;
  assign out_pred_taken = head.pred_taken;

`ifdef FETCH_STATIC_PREDICT_EN
  // Static prediction on the arriving instruction: JAL and backward branches go taken.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = inflight_pc;
    if (imem_rdata[6:0] == OPC_JAL) begin
      pred_taken  = 1'b1;
      pred_target = inflight_pc + XLEN'(signed'(j_imm(imem_rdata)));
    end else if (imem_rdata[6:0] == OPC_BRANCH && imem_rdata[31]) begin
      pred_taken  = 1'b1;
      pred_target = inflight_pc + XLEN'(signed'(b_imm(imem_rdata)));
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = inflight_pc;
`endif

  // PC, in-flight tracking and drop flag; reset beats redirect beats prediction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (inflight && drop) drop <= 1'b0;
      if (push && pred_taken) begin
        pc   <= pred_target;
        drop <= issue;
      end else if (issue) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_entry(push_entry),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end replacing the single-register fetch stage. It owns the program counter, issues one-per-cycle requests to a fixed-latency instruction memory, and buffers fetched {pc, instr} pairs in a DEPTH-entry queue. The queue drives decode through a valid/ready handshake, and execute can redirect the PC with a flush. Decode no longer has to sit in lockstep with memory.

## Interface
- XLEN, 32, data/address width
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 0, PC loaded on reset

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request this cycle
- imem_addr  out  XLEN  fetch address, word aligned
- imem_rdata  in  32  instruction; valid exactly 1 cycle after imem_req
- redirect_valid  in  1  branch/jump resolved taken; flush and refetch
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  32  head instruction
- out_pred_taken  out  1  head was predicted taken (0 when prediction compiled out)

## Operation
- State: pc, queue (wptr, rptr, count), inflight bit + inflight_pc, drop bit.
- Issue: imem_req=1, imem_addr=pc when count + inflight < DEPTH and no redirect this cycle; pc += 4 on issue.
- Response: cycle after issue, if drop=0, push {inflight_pc, imem_rdata} into queue; if drop=1, discard and clear drop.
- Pop: out_valid && out_ready removes head.
- Redirect: pc <= {redirect_pc[XLEN-1:2],2'b00}; queue emptied; any response arriving next cycle is discarded (drop=1 if a request is in flight this cycle); no issue this cycle.
- Redirect wins over simultaneous push, pop and issue; an accepted pop that cycle counts as consumed.
- Push and pop same cycle: count unchanged. Push never occurs when full (guaranteed by issue rule).
- pc wraps modulo 2^XLEN without flag.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, out_pred_taken=0, count=0, inflight=0, drop=0, pc=RESET_PC.
- First cycle after reset: request RESET_PC. out_valid rises 2 cycles after a request: request in C, data in C+1, registered into the queue at end of C+1, visible in C+2.
- Sustained 1 instr/cycle with out_ready held high.
- Redirect in cycle R: request to the new PC in R+1; new instruction at out_valid in R+3.
- out_* are registered from queue storage and stable while out_valid && !out_ready.
- reset mid-operation overrides everything in the same edge, including a simultaneous redirect.

## Configuration
- FETCH_STATIC_PREDICT_EN defined: on push, if the opcode is JAL (7'b1101111), predict taken. If the opcode is BRANCH (7'b1100011) with a negative B-immediate (sign bit instr[31]), also predict taken. A predicted-taken push sets the entry's pred_taken bit, loads pc <= entry_pc + sign-extended imm, and sets drop for the sequential request issued that cycle. This costs 1 bubble. An external redirect in the same cycle takes priority and suppresses the prediction.
- Undefined: no prediction logic; out_pred_taken tied 0; purely sequential fetch.

## Structure
- Package fetch_pkg: OPC_JAL, OPC_BRANCH constants; fetch_entry_t struct {pc, instr, pred_taken}; B/J immediate extract functions.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty.

## Test plan
- Reset, RESET_PC=0x100, out_ready=1 -> imem_addr 0x100, 0x104, 0x108 on successive cycles; out_pc 0x100 appears 2 cycles after the first request.
- out_ready=0 with DEPTH=4 -> exactly 4 entries queued, imem_req drops to 0, head stays 0x100; release ready -> 4 pops then streaming resumes without loss or duplicate.
- redirect_valid with redirect_pc=0x203 while queue holds 3 entries -> out_valid=0 next cycle, in-flight response discarded, next request 0x200, out_pc 0x200 three cycles later.
- Redirect and pop in the same cycle, plus redirect on a reset cycle -> reset state wins; otherwise the flush wins with no stale entry.
- FETCH_STATIC_PREDICT_EN: BEQ at 0x110 with imm -16 -> out_pred_taken=1 for 0x110, next out_pc 0x100, 0x114 never output. Forward BEQ -> sequential flow, pred_taken 0.
- Macro undefined, same program -> 0x114 follows 0x110, out_pred_taken always 0.
